// File: rtl/argmax_sched.sv
// argmax_sched: sequencing controller for the CNN classification tail.
// It collects NUM_CLASS unsigned scores, one per valid/ready handshake, after a
// start pulse. It tracks the running maximum and publishes the winning class index
// on a valid/ready result port.
// A frame aborts with a one-cycle err pulse if the score stream stalls for
// TIMEOUT cycles.
// Build option: define ARGMAX_SEG_EN to build the seven-segment encoder and
// the res_seg register; otherwise res_seg is tied to 8'hFF (blank).
module argmax_sched #(
    parameter int unsigned NUM_CLASS = 10,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              score_valid,
    output logic              score_ready,
    input  logic [DATA_W-1:0] score_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [3:0]        res_class,
    output logic [7:0]        res_seg,
    output logic              busy,
    output logic              err
);

    localparam int unsigned IDX_W = 4;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASS - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RESULT  = 2'd2
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] best_val;
    logic [IDX_W-1:0]  best_idx;
    logic [TO_W-1:0]   to_cnt;

    logic             accept_c;
    logic             take_new_c;
    logic             final_accept_c;
    logic [IDX_W-1:0] upd_idx_c;

    // Handshake decode and post-update winner of the current accept
    always_comb begin
        accept_c       = (state == COLLECT) && score_valid && score_ready;
        take_new_c     = (idx == '0) || (score_data > best_val);
        upd_idx_c      = take_new_c ? idx : best_idx;
        final_accept_c = accept_c && (idx == LAST_IDX);
    end

    // Frame sequencing: collect scores, track maximum, publish, abort on stall
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            score_ready <= 1'b0;
            res_valid   <= 1'b0;
            res_class   <= '0;
            busy        <= 1'b0;
            err         <= 1'b0;
            idx         <= '0;
            best_val    <= '0;
            best_idx    <= '0;
            to_cnt      <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= COLLECT;
                        score_ready <= 1'b1;
                        busy        <= 1'b1;
                        idx         <= '0;
                        best_val    <= '0;
                        best_idx    <= '0;
                        to_cnt      <= '0;
                    end
                end
                COLLECT: begin
                    if (accept_c) begin
                        to_cnt <= '0;
                        idx    <= idx + IDX_W'(1);
                        if (take_new_c) begin
                            best_val <= score_data;
                            best_idx <= idx;
                        end
                        if (final_accept_c) begin
                            state       <= RESULT;
                            score_ready <= 1'b0;
                            res_valid   <= 1'b1;
                            res_class   <= upd_idx_c;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        // Stalled stream: drop the frame, keep the last result on display
                        state       <= IDLE;
                        score_ready <= 1'b0;
                        busy        <= 1'b0;
                        err         <= 1'b1;
                        to_cnt      <= '0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    score_ready <= 1'b0;
                    res_valid   <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARGMAX_SEG_EN
    // Active-low seven-segment pattern, decimal point off; dash beyond 9
    function automatic logic [7:0] seg_encode(input logic [IDX_W-1:0] c);
        case (c)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hBF;
        endcase
    endfunction

    // Display code loads together with res_class and holds otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            res_seg <= 8'hFF;
        end else if (final_accept_c) begin
            res_seg <= seg_encode(upd_idx_c);
        end
    end
`else
    assign res_seg = 8'hFF;
`endif

endmodule

// File: tb/tb_argmax_sched.sv
// Directed bench for argmax_sched with a result scoreboard.
// The DUT is built with TIMEOUT=8. Segment expectations follow ARGMAX_SEG_EN.
module tb_argmax_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        score_valid;
    logic        score_ready;
    logic [15:0] score_data;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_class;
    logic [7:0]  res_seg;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] cls;
        logic [7:0] seg;
    } exp_t;

    exp_t sb[$];
    logic [3:0] last_cls;
    logic [7:0] last_seg;

    argmax_sched #(.NUM_CLASS(10), .DATA_W(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .score_valid(score_valid), .score_ready(score_ready), .score_data(score_data),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_class(res_class), .res_seg(res_seg),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_seg(input int c);
        logic [7:0] s;
        case (c)
            0: s = 8'hC0;  1: s = 8'hF9;  2: s = 8'hA4;  3: s = 8'hB0;
            4: s = 8'h99;  5: s = 8'h92;  6: s = 8'h82;  7: s = 8'hF8;
            8: s = 8'h80;  9: s = 8'h90;  default: s = 8'hBF;
        endcase
`ifndef ARGMAX_SEG_EN
        s = 8'hFF;
`endif
        return s;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_score_ready"}, 32'(score_ready), 32'd0);
        check({tag, "_res_valid"},   32'(res_valid),   32'd0);
        check({tag, "_res_class"},   32'(res_class),   32'd0);
        check({tag, "_res_seg"},     32'(res_seg),     32'hFF);
        check({tag, "_busy"},        32'(busy),        32'd0);
        check({tag, "_err"},         32'(err),         32'd0);
    endtask

    // One complete frame: gap idle cycles before each score, hold cycles of res_ready low
    task automatic run_frame(input string tag, input logic [15:0] sc [10],
                             input int gap, input int hold, input bit start_mid);
        int   best;
        exp_t e;
        best = 0;
        for (int i = 1; i < 10; i++) if (sc[i] > sc[best]) best = i;
        e.cls = 4'(best);
        e.seg = exp_seg(best);
        sb.push_back(e);

        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_start"},  32'(busy),        32'd1);
        check({tag, "_ready_start"}, 32'(score_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            for (int g = 0; g < gap; g++) begin
                score_valid = 1'b0;
                tick();
            end
            score_valid = 1'b1;
            score_data  = sc[i];
            start       = start_mid && (i % 3 == 1);
            if (i == 9 && hold == 0) res_ready = 1'b1;
            tick();
        end
        score_valid = 1'b0;
        start       = 1'b0;

        check({tag, "_res_valid_rise"}, 32'(res_valid), 32'd1);
        if (res_valid && sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_res_class"}, 32'(res_class), 32'(e.cls));
            check({tag, "_res_seg"},   32'(res_seg),   32'(e.seg));
            last_cls = e.cls;
            last_seg = e.seg;
        end
        for (int h = 0; h < hold; h++) begin
            start = start_mid;
            tick();
            check({tag, "_res_valid_hold"}, 32'(res_valid), 32'd1);
            check({tag, "_res_class_hold"}, 32'(res_class), 32'(last_cls));
        end
        start     = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_res_valid_fall"}, 32'(res_valid),   32'd0);
        check({tag, "_busy_end"},       32'(busy),        32'd0);
        check({tag, "_ready_end"},      32'(score_ready), 32'd0);
    endtask

    initial begin
        logic [15:0] f1 [10];
        logic [15:0] f2 [10];
        logic [15:0] f3 [10];
        logic [15:0] f4 [10];

        f1 = '{16'd5, 16'd9, 16'd3, 16'd40, 16'd7, 16'd40, 16'd1, 16'd0, 16'd2, 16'd6};
        f2 = '{16'd100, 16'd200, 16'd50, 16'hFFFE, 16'd3, 16'd7, 16'hFFFE, 16'd1, 16'd2, 16'hFFFF};
        f3 = '{16'd10, 16'd20, 16'd300, 16'd300, 16'd5, 16'd299, 16'd1, 16'd0, 16'd300, 16'd2};
        f4 = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        last_cls = 4'd0;
        last_seg = 8'hFF;

        rst = 1'b1; start = 1'b0; score_valid = 1'b0; score_data = '0; res_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_state("reset");
        for (int k = 0; k < 6; k++) tick();
        check_reset_state("idle");

        // Back-to-back frame with a tie; res_ready already high at res_valid
        run_frame("single", f1, 0, 0, 1'b0);

        // Gapped scores, maximum at the last class, result held under backpressure
        run_frame("bp", f2, 3, 4, 1'b0);

        // Stall after four scores
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            score_valid = 1'b1;
            score_data  = 16'(i + 1);
            tick();
        end
        score_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 8) check("to_err_early", 32'(err), 32'd0);
            if (k == 7) check("to_busy_before", 32'(busy), 32'd1);
        end
        check("to_err",       32'(err),         32'd1);
        check("to_busy",      32'(busy),        32'd0);
        check("to_ready",     32'(score_ready), 32'd0);
        check("to_res_valid", 32'(res_valid),   32'd0);
        check("to_res_class", 32'(res_class),   32'(last_cls));
        check("to_res_seg",   32'(res_seg),     32'(last_seg));
        tick();
        check("to_err_pulse", 32'(err),  32'd0);
        check("to_busy_after", 32'(busy), 32'd0);

        // Start pulses during COLLECT and RESULT must not disturb the frame
        run_frame("startign", f3, 0, 2, 1'b1);

        // Reset after six accepts discards the partial frame
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            score_valid = 1'b1;
            score_data  = 16'(1000 + i);
            tick();
        end
        score_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("midrst");
        last_cls = 4'd0;
        last_seg = 8'hFF;

        // All-equal scores keep class 0
        run_frame("post_rst", f4, 0, 1, 1'b0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
